// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions: decoder FSM states and the window/scale
// widths that the MAC-side Sobol generators also depend on.
package sc_pkg;

  localparam int SC_WIN_LOG2   = 8;
  localparam int SC_SCALE_LOG2 = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } sc_dec_state_t;

endpackage

// File: rtl/sc_win_cnt.sv
// Window sample counter and ones counter; both advance only on enabled cycles
// and clear together so a new window always starts from zero.
import sc_pkg::*;

module sc_win_cnt #(
  parameter int WIN_LOG2 = SC_WIN_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              bit_in,
  output logic [WIN_LOG2:0] ones,
  output logic              tc,
  output logic [WIN_LOG2:0] ones_nxt
);

  localparam logic [WIN_LOG2:0] LAST_SAMP = (WIN_LOG2+1)'((1 << WIN_LOG2) - 1);
  localparam logic [WIN_LOG2:0] ONE       = (WIN_LOG2+1)'(1);

  logic [WIN_LOG2:0] samp;

  assign ones_nxt = bit_in ? ones + ONE : ones;
  // tc marks the cycle whose enabled sample completes the window
  assign tc       = en && (samp == LAST_SAMP);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      samp <= '0;
      ones <= '0;
    end else if (en) begin
      samp <= samp + ONE;
      ones <= ones_nxt;
    end
  end

endmodule

// File: rtl/sc_bi_scaled_decoder.sv
// Bipolar stochastic decoder: counts ones over a fixed enabled-sample window and
// returns (2*P - 2^WIN_LOG2) << SCALE_LOG2 on a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for start; outputs keep the last result
//   ACCUM | sampling iBit on iEn cycles (busy=1)
//   HOLD  | result presented (oValid=1) until oReady
import sc_pkg::*;

module sc_bi_scaled_decoder #(
  parameter int  WIN_LOG2   = SC_WIN_LOG2,
  parameter int  SCALE_LOG2 = SC_SCALE_LOG2,
  localparam int OUT_W      = WIN_LOG2 + SCALE_LOG2 + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    iBit,
  input  logic                    iEn,
  input  logic                    start,
  output logic                    busy,
  output logic signed [OUT_W-1:0] oSum,
  output logic [WIN_LOG2:0]       oOnes,
  output logic                    oValid,
  input  logic                    oReady
);

  localparam logic [WIN_LOG2+1:0] WIN_LEN = {2'b01, {WIN_LOG2{1'b0}}};

  sc_dec_state_t state;

  logic                       cnt_clr;
  logic                       cnt_en;
  logic                       tc;
  logic                       handshake;
  logic [WIN_LOG2:0]          ones_nxt;
  logic [WIN_LOG2:0]          cur_ones_unused;
  logic signed [WIN_LOG2+1:0] offset;

  assign busy      = (state == ACCUM);
  assign oValid    = (state == HOLD);
  assign handshake = oValid && oReady;
  assign cnt_en    = busy && iEn;
  assign cnt_clr   = ((state == IDLE) || handshake) && start;

  // 2P - 2^W is exact in W+2 signed bits, so the scaled result needs no saturation
  assign offset = $signed({ones_nxt, 1'b0} - WIN_LEN);

  sc_win_cnt #(
    .WIN_LOG2(WIN_LOG2)
  ) u_win_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .bit_in   (iBit),
    .ones     (cur_ones_unused),
    .tc       (tc),
    .ones_nxt (ones_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      oSum  <= '0;
      oOnes <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= ACCUM;
        end
        ACCUM: begin
          if (tc) begin
            state <= HOLD;
            oOnes <= ones_nxt;
            oSum  <= {offset, {SCALE_LOG2{1'b0}}};
          end
        end
        HOLD: begin
          // start with oReady chains straight into the next window
          if (oReady) state <= start ? ACCUM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
